// File: rtl/pixel_tap_shift_reg_if.sv
// ----------------------------------------------------------------------------
// pixel_tap_shift_reg_if
// Pixel stream bundle between a pixel source and the tap shift register.
//
// Handshake: valid-only stream, no backpressure. A pixel is transferred on
// every rising clock edge where in_valid=1; the consumer must always accept.
// On the output side out_valid=1 marks the single cycle in which taps_out
// holds a freshly completed window; the sink must capture it that cycle.
//
// Signals
//   in_valid   : pixel_in is presented this cycle (master -> slave)
//   pixel_in   : incoming pixel, WIDTH bits         (master -> slave)
//   sol        : start of line, qualified by in_valid (master -> slave)
//   flush      : shift in one padding pixel         (master -> slave)
//   taps_out   : window, [WIDTH-1:0] newest tap     (slave -> master)
//   out_valid  : new complete window this cycle     (slave -> master)
//   fill_level : number of valid taps, saturating   (slave -> master)
// ----------------------------------------------------------------------------
interface pixel_tap_shift_reg_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
);
   logic                         in_valid;
   logic [WIDTH-1:0]             pixel_in;
   logic                         sol;
   logic                         flush;
   logic [DEPTH*WIDTH-1:0]       taps_out;
   logic                         out_valid;
   logic [$clog2(DEPTH+1)-1:0]   fill_level;

   modport master (
      output in_valid, pixel_in, sol, flush,
      input  taps_out, out_valid, fill_level
   );

   modport slave (
      input  in_valid, pixel_in, sol, flush,
      output taps_out, out_valid, fill_level
   );
endinterface

// File: rtl/pixel_tap_shift_reg.sv
// ----------------------------------------------------------------------------
// pixel_tap_shift_reg
// Horizontal DEPTH-tap window generator for the edge-detection datapath.
// Each accepted pixel shifts into tap[0]; tap[DEPTH-1] is the oldest.
// Row boundaries are handled by start-of-line (sol) restart with optional
// padding, and by end-of-line flush that shifts in a padding pixel.
//
// Parameters
//   WIDTH    : bits per pixel (>=1)
//   DEPTH    : number of taps (>=2)
//   PAD_MODE : 0 = none (wait for fill), 1 = zero pad, 2 = replicate edge
//
// Ports
//   i_clock : single clock, rising edge
//   i_reset : synchronous, active-high reset (highest priority)
//   bus     : slave side of pixel_tap_shift_reg_if (stream in, window out)
// ----------------------------------------------------------------------------
module pixel_tap_shift_reg #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 3,
   parameter int PAD_MODE = 0
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   pixel_tap_shift_reg_if.slave   bus
);
   localparam int FW = $clog2(DEPTH + 1);
   localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

   logic [WIDTH-1:0] r_tap [DEPTH];
   logic [FW-1:0]    r_fill;
   logic             r_out_valid;

   logic [WIDTH-1:0] w_tap_next [DEPTH];
   logic [FW-1:0]    w_fill_next;
   logic             w_accept;
   logic             w_flush_eff;
   logic [WIDTH-1:0] w_pad;

   assign w_accept = bus.in_valid;

   // A flush only counts when there is something to drain, a padding policy
   // exists, and no real pixel competes for the same cycle.
   assign w_flush_eff = bus.flush && !bus.in_valid && (r_fill != '0) &&
                        (PAD_MODE != 0);

   // Replicate mode pads with the current edge pixel, zero mode with 0.
   assign w_pad = (PAD_MODE == 2) ? r_tap[0] : '0;

   always_comb begin
      w_tap_next  = r_tap;
      w_fill_next = r_fill;
      if (w_accept && bus.sol) begin
         // New row: prior window contents are discarded.
         for (int i = 1; i < DEPTH; i++) begin
            w_tap_next[i] = (PAD_MODE == 2) ? bus.pixel_in : '0;
         end
         w_tap_next[0] = bus.pixel_in;
         w_fill_next   = (PAD_MODE == 0) ? FW'(1) : FILL_FULL;
      end else if (w_accept) begin
         for (int i = 1; i < DEPTH; i++) begin
            w_tap_next[i] = r_tap[i-1];
         end
         w_tap_next[0] = bus.pixel_in;
         w_fill_next   = (r_fill == FILL_FULL) ? r_fill : r_fill + FW'(1);
      end else if (w_flush_eff) begin
         // Drain shift; fill is deliberately left unchanged.
         for (int i = 1; i < DEPTH; i++) begin
            w_tap_next[i] = r_tap[i-1];
         end
         w_tap_next[0] = w_pad;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_tap[i] <= '0;
         end
         r_fill      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_tap       <= w_tap_next;
         r_fill      <= w_fill_next;
         r_out_valid <= (w_accept || w_flush_eff) && (w_fill_next == FILL_FULL);
      end
   end

   // Pack taps so the newest pixel lands in the lowest slice.
   for (genvar g = 0; g < DEPTH; g++) begin : g_pack
      assign bus.taps_out[g*WIDTH +: WIDTH] = r_tap[g];
   end

   assign bus.out_valid  = r_out_valid;
   assign bus.fill_level = r_fill;
endmodule

// File: tb/tb_pixel_tap_shift_reg.sv
module tb_pixel_tap_shift_reg;
  localparam int W = 8;
  localparam int D = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // One DUT per padding policy, each with its own stream bundle.
  pixel_tap_shift_reg_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
  pixel_tap_shift_reg_if #(.WIDTH(W), .DEPTH(D)) bus1 ();
  pixel_tap_shift_reg_if #(.WIDTH(W), .DEPTH(D)) bus2 ();

  pixel_tap_shift_reg #(.WIDTH(W), .DEPTH(D), .PAD_MODE(0)) dut0 (
    .i_clock(clk), .i_reset(rst), .bus(bus0.slave));
  pixel_tap_shift_reg #(.WIDTH(W), .DEPTH(D), .PAD_MODE(1)) dut1 (
    .i_clock(clk), .i_reset(rst), .bus(bus1.slave));
  pixel_tap_shift_reg #(.WIDTH(W), .DEPTH(D), .PAD_MODE(2)) dut2 (
    .i_clock(clk), .i_reset(rst), .bus(bus2.slave));

  logic         d_valid [3];
  logic [W-1:0] d_pix   [3];
  logic         d_sol   [3];
  logic         d_flush [3];

  assign bus0.in_valid = d_valid[0]; assign bus0.pixel_in = d_pix[0];
  assign bus0.sol      = d_sol[0];   assign bus0.flush    = d_flush[0];
  assign bus1.in_valid = d_valid[1]; assign bus1.pixel_in = d_pix[1];
  assign bus1.sol      = d_sol[1];   assign bus1.flush    = d_flush[1];
  assign bus2.in_valid = d_valid[2]; assign bus2.pixel_in = d_pix[2];
  assign bus2.sol      = d_sol[2];   assign bus2.flush    = d_flush[2];

  // ---------------- scoreboard ----------------
  logic [D*W-1:0] exp_q0[$];
  logic [D*W-1:0] exp_q1[$];
  logic [D*W-1:0] exp_q2[$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int m, input logic [D*W-1:0] v);
    case (m)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic pop_chk(input int m, input logic [D*W-1:0] act);
    logic [D*W-1:0] e;
    int sz;
    sz = (m == 0) ? exp_q0.size() : (m == 1) ? exp_q1.size() : exp_q2.size();
    n_total++;
    if (sz == 0) begin
      n_bad++;
      $display("FAIL win%0d_unexpected: out_valid=1 taps=0x%0h expected no window at %0t",
               m, act, $time);
    end else begin
      case (m)
        0: e = exp_q0.pop_front();
        1: e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      if (act !== e) begin
        n_bad++;
        $display("FAIL win%0d: taps=0x%0h expected 0x%0h at %0t", m, act, e, $time);
      end
    end
  endtask

  // Monitors: compare every presented window against the expected queue.
  always @(negedge clk) if (bus0.out_valid === 1'b1) pop_chk(0, bus0.taps_out);
  always @(negedge clk) if (bus1.out_valid === 1'b1) pop_chk(1, bus1.taps_out);
  always @(negedge clk) if (bus2.out_valid === 1'b1) pop_chk(2, bus2.taps_out);

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      d_valid[i] = 1'b0; d_pix[i] = '0; d_sol[i] = 1'b0; d_flush[i] = 1'b0;
    end
  endtask

  // One clock with the given inputs on instance m; returns at the next negedge.
  task automatic cyc(input int m, input logic v, input logic [W-1:0] p,
                     input logic s, input logic f);
    d_valid[m] = v; d_pix[m] = p; d_sol[m] = s; d_flush[m] = f;
    @(posedge clk);
    @(negedge clk);
    idle_all();
  endtask

  task automatic gap();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_fill(input int m, input int exp);
    logic [31:0] a;
    a = (m == 0) ? 32'(bus0.fill_level) : (m == 1) ? 32'(bus1.fill_level) : 32'(bus2.fill_level);
    chk($sformatf("fill%0d", m), a, 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_taps0", 32'(bus0.taps_out), 32'h0);
    chk("rst_valid0", 32'(bus0.out_valid), 32'h0);
    chk_fill(0, 0); chk_fill(1, 0); chk_fill(2, 0);

    // Fill, PAD_MODE 0
    cyc(0, 1, 8'h0A, 0, 0); chk_fill(0, 1);
    cyc(0, 1, 8'h14, 0, 0); chk_fill(0, 2);
    push(0, 24'h0A141E);
    cyc(0, 1, 8'h1E, 0, 0); chk_fill(0, 3);
    push(0, 24'h141E28);
    cyc(0, 1, 8'h28, 0, 0); chk_fill(0, 3);

    // Row restart, PAD_MODE 0
    cyc(0, 1, 8'h32, 1, 0); chk_fill(0, 1);
    chk("sol_taps0", 32'(bus0.taps_out), 32'h000032);
    cyc(0, 1, 8'h3C, 0, 0); chk_fill(0, 2);
    push(0, 24'h323C46);
    cyc(0, 1, 8'h46, 0, 0); chk_fill(0, 3);

    // Flush ignored in PAD_MODE 0
    cyc(0, 0, 8'h00, 0, 1); chk_fill(0, 3);
    chk("flush_m0_taps", 32'(bus0.taps_out), 32'h323C46);

    // Replicate, PAD_MODE 2: flush path
    push(2, 24'h050505); cyc(2, 1, 8'h05, 1, 0); chk_fill(2, 3);
    push(2, 24'h050506); cyc(2, 1, 8'h06, 0, 0);
    push(2, 24'h050606); cyc(2, 0, 8'h00, 0, 1); chk_fill(2, 3);
    // Replicate: flush coinciding with a pixel is dropped
    push(2, 24'h050505); cyc(2, 1, 8'h05, 1, 0);
    push(2, 24'h050506); cyc(2, 1, 8'h06, 0, 0);
    push(2, 24'h050607); cyc(2, 1, 8'h07, 0, 1);

    // Zero pad, PAD_MODE 1
    push(1, 24'h000009); cyc(1, 1, 8'h09, 1, 0); chk_fill(1, 3);
    push(1, 24'h000900); cyc(1, 0, 8'h00, 0, 1);
    push(1, 24'h090000); cyc(1, 0, 8'h00, 0, 1); chk_fill(1, 3);
    // sol without in_valid is ignored
    cyc(1, 0, 8'hEE, 1, 0); chk_fill(1, 3);
    chk("sol_noval_taps1", 32'(bus1.taps_out), 32'h090000);

    // Gaps, PAD_MODE 0
    cyc(0, 1, 8'h01, 1, 0); gap(); chk_fill(0, 1);
    cyc(0, 1, 8'h02, 0, 0); gap(); chk_fill(0, 2);
    push(0, 24'h010203);
    cyc(0, 1, 8'h03, 0, 0); gap(); chk_fill(0, 3);
    chk("gap_hold_taps0", 32'(bus0.taps_out), 32'h010203);
    push(0, 24'h020304);
    cyc(0, 1, 8'h04, 0, 0); gap();
    chk("gap_hold2_taps0", 32'(bus0.taps_out), 32'h020304);

    // Reset mid-row (reset wins over a concurrent pixel)
    cyc(0, 1, 8'h10, 1, 0);
    cyc(0, 1, 8'h11, 0, 0); chk_fill(0, 2);
    rst = 1'b1; d_valid[0] = 1'b1; d_pix[0] = 8'h55;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; idle_all();
    chk("midrst_taps0", 32'(bus0.taps_out), 32'h0);
    chk("midrst_valid0", 32'(bus0.out_valid), 32'h0);
    chk_fill(0, 0);

    // Flush before any pixel is ignored, even with a padding policy
    cyc(1, 0, 8'h00, 0, 1); chk_fill(1, 0);
    chk("flush_empty_taps1", 32'(bus1.taps_out), 32'h0);
    cyc(2, 0, 8'h00, 0, 1); chk_fill(2, 0);

    cyc(0, 1, 8'h21, 0, 0); chk_fill(0, 1);
    cyc(0, 1, 8'h22, 0, 0); chk_fill(0, 2);
    push(0, 24'h212223);
    cyc(0, 1, 8'h23, 0, 0); chk_fill(0, 3);

    gap(); gap();

    // Every expected window must have been seen.
    chk("q0_left", 32'(exp_q0.size()), 32'h0);
    chk("q1_left", 32'(exp_q1.size()), 32'h0);
    chk("q2_left", 32'(exp_q2.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
